// File: rtl/im_pkg.sv
// Shared types, widths and address helpers for the instruction-memory arbiter.
package im_pkg;

    localparam int unsigned IM_AW  = 10;
    localparam int unsigned IM_DW  = 32;
    localparam int unsigned IM_BAW = 12;  // requester byte-address width
    localparam int unsigned IM_SCW = 4;   // starvation counter width

    // Tag of the response due on the cycle after a grant.
    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LOAD  = 2'd2
    } rsp_t;

    // Word index of a byte address.
    function automatic logic [IM_AW-1:0] word_idx(input logic [IM_BAW-1:0] addr);
        return addr[IM_BAW-1:2];
    endfunction

    function automatic logic is_misaligned(input logic [IM_BAW-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/im_starve_ctr.sv
// Saturating counter with synchronous clear, used to bound loader wait time.
module im_starve_ctr
    import im_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [IM_SCW-1:0] cnt
);

    logic [IM_SCW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt < IM_SCW'(MAX))) begin
            cnt_d = cnt + IM_SCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/im_arbiter.sv
// Arbitrates the single-port IM between CPU fetch and the loader/debug port.
// Loader path, starvation counter and write support exist only when IM_LOADER_EN is defined.
module im_arbiter
    import im_pkg::*;
#(
    parameter int unsigned AW         = IM_AW,
    parameter int unsigned DW         = IM_DW,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [IM_BAW-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DW-1:0]     fetch_rdata,
    input  logic              load_req,
    input  logic              load_we,
    input  logic [IM_BAW-1:0] load_addr,
    input  logic [DW-1:0]     load_wdata,
    output logic              load_gnt,
    output logic              load_rvalid,
    output logic [DW-1:0]     load_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              misalign_err
);

    rsp_t              rsp_q;
    rsp_t              rsp_d;
    logic [AW-1:0]     addr_q;
    logic              misalign_q;
    logic              misalign_d;
    logic [IM_BAW-1:0] win_addr;
    logic              load_rd_gnt;

`ifdef IM_LOADER_EN
    logic [IM_SCW-1:0] starve_cnt;
    logic              starved;
    logic              load_win;
    logic [DW-1:0]     wdata_q;

    // Loader wins when alone, or when it has waited STARVE_MAX cycles.
    assign starved   = starve_cnt >= IM_SCW'(STARVE_MAX);
    assign load_win  = ~rst & load_req & (~fetch_req | starved);
    assign load_gnt  = load_win;
    assign fetch_gnt = ~rst & fetch_req & ~load_win;

    im_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (load_req & ~load_win),
        .clr (~load_req | load_win),
        .cnt (starve_cnt)
    );

    assign load_rd_gnt = load_gnt & ~load_we;
    assign mem_we      = load_gnt & load_we;
    assign load_rvalid = (rsp_q == RSP_LOAD);
    assign load_rdata  = mem_rdata;
    assign win_addr    = load_gnt ? load_addr : fetch_addr;
    assign mem_wdata   = mem_en ? load_wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
        end else if (mem_en) begin
            wdata_q <= load_wdata;
        end
    end
`else
    logic                    unused_loader;
    localparam int unsigned  unused_starve_max = STARVE_MAX;

    assign unused_loader = ^{load_req, load_we, load_addr, load_wdata};
    assign fetch_gnt     = ~rst & fetch_req;
    assign load_gnt      = 1'b0;
    assign load_rd_gnt   = 1'b0;
    assign mem_we        = 1'b0;
    assign load_rvalid   = 1'b0;
    assign load_rdata    = '0;
    assign win_addr      = fetch_addr;
    assign mem_wdata     = '0;
`endif

    // Memory port: address holds its last granted value while idle.
    assign mem_en   = fetch_gnt | load_gnt;
    assign mem_addr = mem_en ? AW'(word_idx(win_addr)) : addr_q;

    always_comb begin
        rsp_d      = RSP_NONE;
        misalign_d = misalign_q;
        if (fetch_gnt) begin
            rsp_d = RSP_FETCH;
        end else if (load_rd_gnt) begin
            rsp_d = RSP_LOAD;
        end
        if (mem_en && is_misaligned(win_addr)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q      <= RSP_NONE;
            addr_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            rsp_q      <= rsp_d;
            misalign_q <= misalign_d;
            if (mem_en) begin
                addr_q <= mem_addr;
            end
        end
    end

    assign fetch_rvalid = (rsp_q == RSP_FETCH);
    assign fetch_rdata  = mem_rdata;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_im_arbiter.sv
// Scoreboard bench for im_arbiter; the reference model follows the IM_LOADER_EN build setting.
module tb_im_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;
    localparam int unsigned NW = 1024;
`ifdef IM_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          fetch_req;
    logic [11:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          load_req;
    logic          load_we;
    logic [11:0]   load_addr;
    logic [DW-1:0] load_wdata;
    logic          load_gnt;
    logic          load_rvalid;
    logic [DW-1:0] load_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          misalign_err;

    im_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .load_req     (load_req),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_wdata   (load_wdata),
        .load_gnt     (load_gnt),
        .load_rvalid  (load_rvalid),
        .load_rdata   (load_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .misalign_err (misalign_err)
    );

    typedef struct {
        int          due;
        bit          is_load;
        logic [31:0] data;
    } exp_t;

    exp_t          expq[$];
    exp_t          e;
    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];
    int            cyc     = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model state
    int            m_denied;
    bit            m_mis;
    bit            m_last_valid;
    logic [9:0]    m_last_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    function automatic logic [11:0] rand_addr();
        int unsigned w;
        int unsigned low;
        w   = $urandom_range(0, 63);
        low = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : 0;
        return 12'(w * 4 + low);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Synchronous-read IM array driven by the DUT memory port.
    initial begin
        for (int i = 0; i < NW; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due or shown.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_stale at cycle %0d: response due at %0d never checked", cyc, expq[0].due);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rsp_tag", 32'({fetch_rvalid, load_rvalid}), e.is_load ? 32'd1 : 32'd2);
            chk("rsp_data", e.is_load ? load_rdata : fetch_rdata, e.data);
        end else if (fetch_rvalid || load_rvalid) begin
            chk("rsp_spurious", 32'({fetch_rvalid, load_rvalid}), 32'd0);
        end
    end

    // One request cycle: drive, check grant/port against the model, queue the response.
    task automatic do_cycle(input logic fr, input logic [11:0] fa, input logic lr, input logic lw,
                            input logic [11:0] la, input logic [31:0] ld,
                            output bit gf, output bit gl, output bit df, output bit dl);
        logic [11:0] a;
        logic [9:0]  word;
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_we    = lw;
        load_addr  = la;
        load_wdata = ld;
        @(negedge clk);
        gl = LOADER && lr && (!fr || m_denied >= int'(SM));
        gf = fr && !gl;
        df = fetch_gnt;
        dl = load_gnt;
        chk("fetch_gnt", 32'(fetch_gnt), 32'(gf));
        chk("load_gnt", 32'(load_gnt), 32'(gl));
        chk("mem_en", 32'(mem_en), 32'(gf || gl));
        chk("mem_we", 32'(mem_we), 32'(gl && lw));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        if (gf || gl) begin
            a    = gl ? la : fa;
            word = 10'(a >> 2);
            chk("mem_addr", 32'(mem_addr), 32'(word));
            if (gl && lw) begin
                chk("mem_wdata", mem_wdata, ld);
                ref_mem[word] = ld;
            end else begin
                expq.push_back('{due: cyc + 1, is_load: gl, data: ref_mem[word]});
            end
            if (a[1:0] != 2'b00) m_mis = 1'b1;
            m_last_valid = 1'b1;
            m_last_word  = word;
        end else if (m_last_valid) begin
            chk("mem_addr_hold", 32'(mem_addr), 32'(m_last_word));
        end
        m_denied = (LOADER && lr && !gl) ? m_denied + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit gf, gl, df, dl;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
    endtask

    // Both requesters held high; returns the DUT grant sequence.
    task automatic starve_run(input int n, output string pat);
        bit gf, gl, df, dl;
        pat = "";
        for (int i = 0; i < n; i++) begin
            do_cycle(1'b1, 12'(12'h100 + i * 4), 1'b1, 1'b0, 12'h020, 32'h0, gf, gl, df, dl);
            if (dl)      pat = {pat, "L"};
            else if (df) pat = {pat, "F"};
            else         pat = {pat, "-"};
        end
    endtask

    task automatic chk_pat(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_denied     = 0;
        m_mis        = 1'b0;
        m_last_valid = 1'b0;
        m_last_word  = '0;
        expq.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_load_gnt", 32'(load_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("rst_load_rvalid", 32'(load_rvalid), 32'd0);
        chk("rst_misalign_err", 32'(misalign_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string       pat;
        bit          gf, gl, df, dl;
        bit          pf, pl;
        logic        fr, lr, lw;
        logic [11:0] fa, la;
        logic [31:0] ld;

        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        model_reset();
        rst        = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 12'h0;
        load_req   = 1'b1;
        load_we    = 1'b1;
        load_addr  = 12'h0;
        load_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch-only stream
        do_cycle(1'b1, 12'h000, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
        do_cycle(1'b1, 12'h004, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
        do_cycle(1'b1, 12'h008, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
        idle(2);

        // Loader write then read-back of the same word
        do_cycle(1'b0, 12'h0, 1'b1, 1'b1, 12'h010, 32'h20110001, gf, gl, df, dl);
        do_cycle(1'b0, 12'h0, 1'b1, 1'b0, 12'h010, 32'h0, gf, gl, df, dl);
        idle(2);
`ifndef IM_LOADER_EN
        chk("load_rdata_tied", load_rdata, 32'h0);
        chk("load_rvalid_tied", 32'(load_rvalid), 32'd0);
`endif

        // Contention with fetch held high
        starve_run(10, pat);
        chk_pat("grant_pattern", pat, LOADER ? "FFFFLFFFFL" : "FFFFFFFFFF");
        idle(2);

        // Misaligned fetch proceeds and sets the sticky flag
        do_cycle(1'b1, 12'h006, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
        idle(3);
        chk("misalign_sticky", 32'(misalign_err), 32'd1);

        // Reset the cycle after a fetch grant drops the response
        do_cycle(1'b1, 12'h040, 1'b0, 1'b0, 12'h0, 32'h0, gf, gl, df, dl);
        rst       = 1'b1;
        model_reset();
        fetch_req = 1'b1;
        load_req  = 1'b1;
        load_we   = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        starve_run(5, pat);
        chk_pat("grant_after_reset", pat, LOADER ? "FFFFL" : "FFFFF");
        idle(2);

        // Randomised traffic honouring the hold-until-granted rule
        pf = 1'b0;
        pl = 1'b0;
        fr = 1'b0; fa = '0; lr = 1'b0; lw = 1'b0; la = '0; ld = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pf) begin
                fr = ($urandom_range(0, 3) != 0);
                fa = rand_addr();
            end
            if (!pl) begin
                lr = ($urandom_range(0, 2) == 0);
                lw = 1'($urandom_range(0, 1));
                la = rand_addr();
                ld = $urandom;
            end
            do_cycle(fr, fa, lr, lw, la, ld, gf, gl, df, dl);
            pf = fr && !gf;
            pl = lr && !gl;
        end
        idle(3);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
